// File: rtl/system_keys_pkg.sv
// Shared constants and helpers for the key-input PIO: register map and the
// debounce default used by the top and the per-bit debouncer.
package system_keys_pkg;

    localparam logic [1:0] KEYS_ADDR_DATA = 2'd0;
    localparam logic [1:0] KEYS_ADDR_RSVD = 2'd1;
    localparam logic [1:0] KEYS_ADDR_MASK = 2'd2;
    localparam logic [1:0] KEYS_ADDR_EDGE = 2'd3;

    // 1 ms at 50 MHz
    localparam int KEYS_DEBOUNCE_DEFAULT = 50000;

    // Pin level seen when the key is released.
    function automatic logic idle_level(input int active_low);
        idle_level = (active_low != 0) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/system_keys_debounce.sv
// One key line: 2-flop synchronizer, stability counter and debounced pressed state.
// press_pulse is high in the cycle whose closing edge raises pressed.
module system_keys_debounce
    import system_keys_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEYS_DEBOUNCE_DEFAULT,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key,
    output logic pressed,
    output logic press_pulse
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic            IDLE_LVL = idle_level(ACTIVE_LOW);

    logic              sync_meta_r;
    logic              sync_r;
    logic              pressed_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              pressed_nxt_s;
    logic              level_s;
    logic              mismatch_s;
    logic              settle_s;

    // Two-stage synchronizer; resets to the released pin level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta_r <= IDLE_LVL;
            sync_r      <= IDLE_LVL;
        end else begin
            sync_meta_r <= key;
            sync_r      <= sync_meta_r;
        end
    end

    assign level_s    = (ACTIVE_LOW != 0) ? ~sync_r : sync_r;
    assign mismatch_s = level_s ^ pressed_r;
    assign settle_s   = mismatch_s && (cnt_r == CNT_LAST);

    // Counter runs only while the synchronized level disagrees; it tops out at
    // CNT_LAST, where the state flips and the count restarts, so it never wraps.
    always_comb begin
        cnt_nxt_s     = '0;
        pressed_nxt_s = pressed_r;
        if (!mismatch_s) begin
            cnt_nxt_s = '0;
        end else if (settle_s) begin
            cnt_nxt_s     = '0;
            pressed_nxt_s = ~pressed_r;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r     <= '0;
            pressed_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            pressed_r <= pressed_nxt_s;
        end
    end

    assign pressed     = pressed_r;
    assign press_pulse = settle_s & ~pressed_r;

endmodule

// File: rtl/system_keys_in.sv
// Avalon-MM key-input PIO: per-bit debounce, press edge capture with W1C,
// interrupt mask, and a zero-wait-state read mux.
module system_keys_in
    import system_keys_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = KEYS_DEBOUNCE_DEFAULT,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] pressed_s;
    logic [WIDTH-1:0] press_s;
    logic [WIDTH-1:0] irqmask_r;
    logic [WIDTH-1:0] edgecap_r;
    logic [WIDTH-1:0] w1c_s;
    logic [31:0]      rdata_s;
    logic             wr_s;
    logic             wr_mask_s;
    logic             wr_unused_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        system_keys_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_debounce (
            .clk         (clk),
            .reset_n     (reset_n),
            .key         (in_port[i]),
            .pressed     (pressed_s[i]),
            .press_pulse (press_s[i])
        );
    end

    assign wr_s        = chipselect & ~write_n;
    assign wr_unused_s = &{1'b0, writedata};

    // Write decode for the mask and the W1C clear vector.
    always_comb begin
        wr_mask_s = 1'b0;
        w1c_s     = '0;
        if (wr_s) begin
            case (address)
                KEYS_ADDR_MASK: wr_mask_s = 1'b1;
                KEYS_ADDR_EDGE: w1c_s     = writedata[WIDTH-1:0];
                default: begin
                    wr_mask_s = 1'b0;
                    w1c_s     = '0;
                end
            endcase
        end else begin
            wr_mask_s = 1'b0;
            w1c_s     = '0;
        end
    end

    // Mask and edge-capture registers; a press on the clearing edge wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_r <= '0;
            edgecap_r <= '0;
        end else begin
            if (wr_mask_s) begin
                irqmask_r <= writedata[WIDTH-1:0];
            end
            edgecap_r <= (edgecap_r & ~w1c_s) | press_s;
        end
    end

    // Read mux; nothing is returned unless selected.
    always_comb begin
        rdata_s = '0;
        if (chipselect) begin
            case (address)
                KEYS_ADDR_DATA: rdata_s[WIDTH-1:0] = pressed_s;
                KEYS_ADDR_MASK: rdata_s[WIDTH-1:0] = irqmask_r;
                KEYS_ADDR_EDGE: rdata_s[WIDTH-1:0] = edgecap_r;
                default:        rdata_s            = '0;
            endcase
        end else begin
            rdata_s = '0;
        end
    end

    assign readdata = rdata_s;
    assign irq      = |(edgecap_r & irqmask_r);

endmodule

// File: tb/tb_system_keys_in.sv
// Directed bench for system_keys_in with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, WIDTH=4.
module tb_system_keys_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    system_keys_in #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
        check(tag, d, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic cs);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        in_port    = 4'hF;
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // Reset and idle
        chk_rd("idle_data", 2'd0, 32'h0);
        chk_rd("idle_rsvd", 2'd1, 32'h0);
        chk_rd("idle_mask", 2'd2, 32'h0);
        chk_rd("idle_edge", 2'd3, 32'h0);
        chk_irq("idle_irq", 1'b0);

        // Press key 0: accepted on edge k+5
        in_port = 4'hE;
        tick(5);
        chk_rd("press_data_k4", 2'd0, 32'h0);
        tick(1);
        chk_rd("press_data_k5", 2'd0, 32'h1);
        chk_rd("press_edge_k5", 2'd3, 32'h1);
        chk_irq("press_irq_masked", 1'b0);
        in_port = 4'hF;
        tick(6);
        chk_rd("release_data", 2'd0, 32'h0);
        chk_rd("release_edge_kept", 2'd3, 32'h1);
        bus_write(2'd3, 32'h1, 1'b1);
        chk_rd("w1c_edge", 2'd3, 32'h0);

        // Bounce: 3-cycle low pulse on key 1 is rejected
        in_port = 4'hD;
        tick(3);
        in_port = 4'hF;
        tick(8);
        chk_rd("bounce_data", 2'd0, 32'h0);
        chk_rd("bounce_edge", 2'd3, 32'h0);

        // 4-cycle low pulse is accepted, release 4 stable cycles later
        in_port = 4'hD;
        tick(4);
        in_port = 4'hF;
        tick(1);
        chk_rd("pulse4_data_k4", 2'd0, 32'h0);
        tick(1);
        chk_rd("pulse4_data_k5", 2'd0, 32'h2);
        chk_rd("pulse4_edge", 2'd3, 32'h2);
        tick(3);
        chk_rd("pulse4_rel_k8", 2'd0, 32'h2);
        tick(1);
        chk_rd("pulse4_rel_k9", 2'd0, 32'h0);
        bus_write(2'd3, 32'h2, 1'b1);

        // Register map: data and reserved ignore writes
        bus_write(2'd0, 32'hF, 1'b1);
        chk_rd("data_ro", 2'd0, 32'h0);
        bus_write(2'd1, 32'hFFFF_FFFF, 1'b1);
        chk_rd("rsvd_zero", 2'd1, 32'h0);

        // Interrupt on key 2
        bus_write(2'd2, 32'hF, 1'b1);
        chk_rd("mask_rd", 2'd2, 32'hF);
        chk_irq("mask_irq_idle", 1'b0);
        in_port = 4'hB;
        tick(5);
        chk_irq("int_irq_k4", 1'b0);
        tick(1);
        chk_irq("int_irq_k5", 1'b1);
        chk_rd("int_edge", 2'd3, 32'h4);
        bus_write(2'd3, 32'h4, 1'b1);
        chk_irq("int_irq_cleared", 1'b0);
        chk_rd("int_edge_cleared", 2'd3, 32'h0);
        in_port = 4'hF;
        tick(6);
        chk_rd("int_rel_edge", 2'd3, 32'h0);
        chk_irq("int_rel_irq", 1'b0);

        // Collision: W1C lands on the same edge as key 1's press
        in_port = 4'hD;
        tick(5);
        chk_rd("coll_edge_before", 2'd3, 32'h0);
        bus_write(2'd3, 32'h2, 1'b1);
        chk_rd("coll_edge_set_wins", 2'd3, 32'h2);
        chk_irq("coll_irq", 1'b1);
        bus_write(2'd2, 32'h0, 1'b0);
        chk_rd("mask_cs0_kept", 2'd2, 32'hF);
        in_port = 4'hF;
        tick(6);
        bus_write(2'd3, 32'h2, 1'b1);
        chk_irq("coll_irq_cleared", 1'b0);

        // Reset mid-debounce with mask 0xF and edge 0x8
        in_port = 4'h7;
        tick(6);
        chk_rd("rst_pre_edge", 2'd3, 32'h8);
        in_port = 4'h6;
        tick(4);
        reset_n = 1'b0;
        #1;
        chk_rd("rst_data", 2'd0, 32'h0);
        chk_rd("rst_mask", 2'd2, 32'h0);
        chk_rd("rst_edge", 2'd3, 32'h0);
        chk_irq("rst_irq", 1'b0);
        tick(2);
        reset_n = 1'b1;
        tick(5);
        chk_rd("rst_redebounce_k4", 2'd0, 32'h0);
        tick(1);
        chk_rd("rst_redebounce_k5", 2'd0, 32'h9);
        chk_rd("rst_redebounce_edge", 2'd3, 32'h9);
        chk_irq("rst_redebounce_irq", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
